// File: rtl/dac_serializer_pkg.sv
// Shared constants and types for the I2S DAC serializer.
// Optional underrun counter build macro: DAC_UNDERRUN_CNT_EN.
package snes_tst_pkg;

  localparam int DAC_SAMPLE_W   = 16;
  localparam int DAC_SLOT_BITS  = 32;
  localparam int DAC_FRAME_W    = 2 * DAC_SLOT_BITS;
  localparam int DAC_UNDERRUN_W = 16;

  typedef enum logic {
    ST_ARM,
    ST_RUN
  } run_t;

endpackage

// File: rtl/dac_serializer_if.sv
// Stereo sample valid/ready handshake bundle.
// master drives samples, slave returns ready.
interface dac_serializer_if
  import snes_tst_pkg::*;
#(
  parameter int SAMPLE_W = DAC_SAMPLE_W
);

  logic [SAMPLE_W-1:0] sample_l;
  logic [SAMPLE_W-1:0] sample_r;
  logic                sample_valid;
  logic                sample_ready;

  modport master (
    output sample_l,
    output sample_r,
    output sample_valid,
    input  sample_ready
  );

  modport slave (
    input  sample_l,
    input  sample_r,
    input  sample_valid,
    output sample_ready
  );

endinterface

// File: rtl/dac_serializer_bclk_gen.sv
// Bit-clock divider: toggles bclk every BCLK_DIV mclocks.
// fall marks the mclock edge on which bclk goes 1 -> 0.
module dac_bclk_gen #(
  parameter int BCLK_DIV = 4
) (
  input  logic mclock,
  input  logic reset_n,
  input  logic enable,
  output logic bclk,
  output logic fall
);

  localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

  logic [DW-1:0] div_cnt;
  logic          wrap;

  assign wrap = (div_cnt == DW'(BCLK_DIV - 1));
  assign fall = enable && wrap && bclk;

  always_ff @(posedge mclock or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
    end else if (!enable) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
    end else if (wrap) begin
      div_cnt <= '0;
      bclk    <= ~bclk;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dac_serializer.sv
// I2S serializer with one-sample holding register; repeats frame on underrun.
// DAC_UNDERRUN_CNT_EN adds a saturating underrun_cnt output.
module dac_serializer
  import snes_tst_pkg::*;
#(
  parameter int SAMPLE_W  = DAC_SAMPLE_W,
  parameter int SLOT_BITS = DAC_SLOT_BITS,
  parameter int BCLK_DIV  = 4
) (
  input  logic mclock,
  input  logic reset_n,
  input  logic enable,
  dac_serializer_if.slave smp,
  output logic dac_bclk,
  output logic dac_lrck,
  output logic dac_data,
  output logic frame_strobe
`ifdef DAC_UNDERRUN_CNT_EN
  ,
  output logic [DAC_UNDERRUN_W-1:0] underrun_cnt
`endif
);

  localparam int FW = 2 * SLOT_BITS;
  localparam int BW = $clog2(FW);

  run_t state, state_nxt;
  logic [BW-1:0] bit_cnt, bit_nxt;
  logic fall, load, last_bit, accept;
  logic hold_full;
  logic [SAMPLE_W-1:0] hold_l, hold_r;
  logic [SLOT_BITS-1:0] slot_l, slot_r;
  logic [FW-1:0] hold_frame, frame, sel_frame, shreg;
  logic dly;

  dac_bclk_gen #(.BCLK_DIV(BCLK_DIV)) u_bclk (
    .mclock (mclock),
    .reset_n(reset_n),
    .enable (enable),
    .bclk   (dac_bclk),
    .fall   (fall)
  );

  assign last_bit = (bit_cnt == BW'(FW - 1));
  assign dac_lrck = (bit_cnt >= BW'(SLOT_BITS));

  always_ff @(posedge mclock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_ARM;
      bit_cnt <= '0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_nxt;
    end
  end

  // ST_ARM: first fall event after enable loads a frame at bit 0
  always_comb begin
    state_nxt = state;
    bit_nxt   = bit_cnt;
    load      = 1'b0;
    unique case (1'b1)
      !enable: begin
        state_nxt = ST_ARM;
        bit_nxt   = '0;
      end
      fall && (state == ST_ARM): begin
        state_nxt = ST_RUN;
        bit_nxt   = '0;
        load      = 1'b1;
      end
      fall && (state == ST_RUN): begin
        bit_nxt = last_bit ? '0 : bit_cnt + 1'b1;
        load    = last_bit;
      end
      default: ;
    endcase
  end

  assign smp.sample_ready = !hold_full;
  assign accept = smp.sample_valid && !hold_full;

  always_ff @(posedge mclock or negedge reset_n) begin
    if (!reset_n) begin
      hold_full <= 1'b0;
      hold_l    <= '0;
      hold_r    <= '0;
    end else if (accept) begin
      hold_full <= 1'b1;
      hold_l    <= smp.sample_l;
      hold_r    <= smp.sample_r;
    end else if (load) begin
      hold_full <= 1'b0;
    end
  end

  assign slot_l     = SLOT_BITS'(hold_l) << (SLOT_BITS - SAMPLE_W);
  assign slot_r     = SLOT_BITS'(hold_r) << (SLOT_BITS - SAMPLE_W);
  assign hold_frame = {slot_l, slot_r};
  assign sel_frame  = hold_full ? hold_frame : frame;

  always_ff @(posedge mclock or negedge reset_n) begin
    if (!reset_n) begin
      frame        <= '0;
      frame_strobe <= 1'b0;
    end else begin
      frame_strobe <= load;
      if (load && hold_full) frame <= hold_frame;
    end
  end

  // dly gives the one-bit I2S delay between shreg and the pin
  always_ff @(posedge mclock or negedge reset_n) begin
    if (!reset_n) begin
      shreg    <= '0;
      dly      <= 1'b0;
      dac_data <= 1'b0;
    end else if (!enable) begin
      shreg    <= '0;
      dly      <= 1'b0;
      dac_data <= 1'b0;
    end else if (load) begin
      dac_data <= dly;
      dly      <= sel_frame[FW-1];
      shreg    <= sel_frame << 1;
    end else if (fall) begin
      dac_data <= dly;
      dly      <= shreg[FW-1];
      shreg    <= shreg << 1;
    end
  end

`ifdef DAC_UNDERRUN_CNT_EN
  always_ff @(posedge mclock or negedge reset_n) begin
    if (!reset_n) begin
      underrun_cnt <= '0;
    end else if (load && !hold_full && (underrun_cnt != '1)) begin
      underrun_cnt <= underrun_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_dac_serializer.sv
// Bench for dac_serializer: frame-level model plus directed checks.
module tb_dac_serializer;
  import snes_tst_pkg::*;

  localparam int DIV = 4;
  localparam int FW  = DAC_FRAME_W;
  localparam int PAD = DAC_SLOT_BITS - DAC_SAMPLE_W;

  logic mclock = 1'b0;
  logic reset_n = 1'b0;
  logic enable = 1'b0;
  logic dac_bclk, dac_lrck, dac_data, frame_strobe;
  logic [DAC_UNDERRUN_W-1:0] underrun_cnt;

  dac_serializer_if #(.SAMPLE_W(DAC_SAMPLE_W)) bus ();

  dac_serializer #(
    .SAMPLE_W (DAC_SAMPLE_W),
    .SLOT_BITS(DAC_SLOT_BITS),
    .BCLK_DIV (DIV)
  ) dut (
    .mclock      (mclock),
    .reset_n     (reset_n),
    .enable      (enable),
    .smp         (bus),
    .dac_bclk    (dac_bclk),
    .dac_lrck    (dac_lrck),
    .dac_data    (dac_data),
    .frame_strobe(frame_strobe)
`ifdef DAC_UNDERRUN_CNT_EN
    ,
    .underrun_cnt(underrun_cnt)
`endif
  );

`ifndef DAC_UNDERRUN_CNT_EN
  assign underrun_cnt = '0;
`endif

  always #5 mclock = ~mclock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: k = mclock edges since enable; fall f = k/(2*DIV); bit n = (f-1)%FW
  int m_k, m_f, m_n;
  bit m_acc;
  logic m_full, m_bclk, m_lrck, m_data, m_strb;
  logic [FW-1:0] m_frame, m_hold;
  logic [15:0] m_und;

  int cap_n = 0;
  int frames_done = 0;
  logic prev_bclk = 1'b0;
  logic [FW-1:0] cap, capl, last_frame, last_lrck;

  always @(posedge mclock) begin
    if (!reset_n) begin
      m_k = 0; m_full = 1'b0; m_frame = '0; m_hold = '0;
      m_bclk = 1'b0; m_lrck = 1'b0; m_data = 1'b0;
      m_strb = 1'b0; m_und = '0;
    end else begin
      m_acc = bus.sample_valid && !m_full;
      m_strb = 1'b0;
      if (!enable) begin
        m_k = 0; m_bclk = 1'b0; m_lrck = 1'b0; m_data = 1'b0;
      end else begin
        m_k++;
        m_bclk = ((m_k / DIV) % 2) == 1;
        if (m_k % (2 * DIV) == 0) begin
          m_f = m_k / (2 * DIV);
          m_n = (m_f - 1) % FW;
          m_lrck = (m_n >= DAC_SLOT_BITS);
          if (m_n == 0) begin
            m_data = (m_f == 1) ? 1'b0 : m_frame[0];
            if (m_full) begin
              m_frame = m_hold;
              m_full = 1'b0;
            end else if (m_und != 16'hFFFF) begin
              m_und++;
            end
            m_strb = 1'b1;
          end else begin
            m_data = m_frame[FW - m_n];
          end
        end
      end
      if (m_acc) begin
        m_full = 1'b1;
        m_hold = {bus.sample_l, {PAD{1'b0}}, bus.sample_r, {PAD{1'b0}}};
      end
    end
    #1;
    chk("bclk", 64'(dac_bclk), 64'(m_bclk));
    chk("lrck", 64'(dac_lrck), 64'(m_lrck));
    chk("data", 64'(dac_data), 64'(m_data));
    chk("strobe", 64'(frame_strobe), 64'(m_strb));
    chk("ready", 64'(bus.sample_ready), 64'(!m_full));
`ifdef DAC_UNDERRUN_CNT_EN
    chk("underrun", 64'(underrun_cnt), 64'(m_und));
`endif
    if (!reset_n || !enable) begin
      cap_n = 0;
    end else if (prev_bclk && !dac_bclk) begin
      if (frame_strobe) cap_n = 0;
      cap[FW-1-cap_n] = dac_data;
      capl[FW-1-cap_n] = dac_lrck;
      cap_n++;
      if (cap_n == FW) begin
        last_frame = cap;
        last_lrck = capl;
        frames_done++;
        cap_n = 0;
      end
    end
    prev_bclk = dac_bclk;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge mclock);
  endtask

  task automatic wait_frames(input int target);
    int lim = 0;
    while (frames_done < target && lim < 3000) begin
      @(negedge mclock);
      lim++;
    end
    if (frames_done < target) chk("frame_timeout", 64'(frames_done), 64'(target));
  endtask

  task automatic wait_cond(input string name, input int sel);
    int lim = 0;
    logic ok = 1'b0;
    while (!ok && lim < 2000) begin
      @(negedge mclock);
      lim++;
      case (sel)
        0: ok = !dac_lrck;
        1: ok = dac_lrck;
        2: ok = bus.sample_ready;
        default: ok = dac_lrck && dac_bclk;
      endcase
    end
    if (!ok) chk(name, 64'(0), 64'(1));
  endtask

  task automatic push(input logic [15:0] l, input logic [15:0] r);
    bus.sample_l = l;
    bus.sample_r = r;
    bus.sample_valid = 1'b1;
    @(negedge mclock);
    bus.sample_valid = 1'b0;
  endtask

  logic [FW-1:0] w1, w2, w3;
  int fd;

  initial begin
    w1 = {1'b0, 16'hA5C3, 16'h0000, 16'h8001, 15'h0000};
    w2 = {1'b0, 16'h1234, 16'h0000, 16'hFEDC, 15'h0000};
    w3 = {1'b0, 16'h7FFF, 16'h0000, 16'h0001, 15'h0000};
    bus.sample_l = '0;
    bus.sample_r = '0;
    bus.sample_valid = 1'b0;
    cyc(3);
    chk("rst_ready", 64'(bus.sample_ready), 64'(1));
    chk("rst_bclk", 64'(dac_bclk), 64'(0));
    chk("rst_strobe", 64'(frame_strobe), 64'(0));
    reset_n = 1'b1;
    enable = 1'b1;

    cyc(100);
    push(16'hA5C3, 16'h8001);
    chk("t2_ready_low", 64'(bus.sample_ready), 64'(0));

    bus.sample_l = 16'h1234;
    bus.sample_r = 16'hFEDC;
    bus.sample_valid = 1'b1;
    cyc(50);
    chk("t3_stall", 64'(bus.sample_ready), 64'(0));
    wait_frames(1);
    chk("t1_frame0", 64'(last_frame), 64'(0));
    chk("t1_lrck", 64'(last_lrck), {32'h0, 32'hFFFF_FFFF});
    wait_cond("t3_ready_to", 2);
    chk("t3_after_load", 64'(frames_done), 64'(1));
    @(negedge mclock);
    bus.sample_valid = 1'b0;
    chk("t3_accepted", 64'(bus.sample_ready), 64'(0));

    wait_frames(2);
    chk("t2_frame1", 64'(last_frame), 64'(w1));
    wait_frames(3);
    chk("t3_frame2", 64'(last_frame), 64'(w2));
`ifdef DAC_UNDERRUN_CNT_EN
    chk("t4_und_start", 64'(underrun_cnt), 64'(1));
`endif
    for (int i = 0; i < 3; i++) begin
      wait_frames(4 + i);
      chk("t4_repeat", 64'(last_frame), 64'(w2));
    end
`ifdef DAC_UNDERRUN_CNT_EN
    chk("t4_und_end", 64'(underrun_cnt), 64'(4));
`endif

    wait_cond("t5_lrck0", 0);
    wait_cond("t5_lrck1", 1);
    cyc(40);
    enable = 1'b0;
    @(posedge mclock);
    #1;
    chk("t5_off", {61'h0, dac_bclk, dac_lrck, dac_data}, 64'(0));
    @(negedge mclock);
    push(16'h7FFF, 16'h0001);
    chk("t5_hs_idle", 64'(bus.sample_ready), 64'(0));
    cyc(30);
    enable = 1'b1;
    fd = frames_done;
    wait_frames(fd + 1);
    chk("t5_fresh", 64'(last_frame), 64'(w3));

    cyc(20);
    push(16'h1111, 16'h2222);
    wait_cond("t6_pos", 3);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_async",
        {59'h0, dac_bclk, dac_lrck, dac_data, frame_strobe, bus.sample_ready},
        64'h1);
    @(negedge mclock);
    reset_n = 1'b1;
    fd = frames_done;
    wait_frames(fd + 1);
    chk("t6_cleared", 64'(last_frame), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
